// File: rtl/uart_in_pkg.sv
// Shared types and helpers for the UART word-input device.
// Pure declarations: no latency, no flow control.
// Module parameters size the counters through cnt_width().
package uart_in_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int BYTES_PER_WORD = 4;

  // Width for a down/up counter holding values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling FSM and shift register.
// byte_ok/byte_ferr pulse combinationally in the cycle whose edge samples the stop bit.
// No backpressure: every frame is reported once and must be consumed in that cycle.
module uart_rx_byte
  import uart_in_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_ok,
  output logic       byte_ferr,
  output logic       idle
);

  localparam int BAUD_W = cnt_width(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

  logic              rx_meta, rxs;
  rx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tick;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q - 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_ok   = 1'b0;
    byte_ferr = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = cnt_q;
        if (!rxs) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (tick) begin
          if (!rxs) begin
            state_d = RX_DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (tick) begin
          state_d   = RX_IDLE;
          byte_ok   = rxs;
          byte_ferr = !rxs;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data = shift_q;
  assign idle      = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_in_dev.sv
// Assembles received UART bytes into 32-bit words for the bridge's device-1 read port.
// dout/status update on the edge that samples the 4th byte's stop bit.
// No backpressure: a new word simply overwrites dout; stale partial words time out.
module uart_in_dev
  import uart_in_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [31:0] dout,
  output logic        word_valid,
  output logic [7:0]  word_cnt,
  output logic        frame_err,
  output logic [1:0]  byte_idx
);

  localparam int IDLE_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IDLE_W     = cnt_width(IDLE_LIMIT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);
  localparam logic [1:0]        LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [7:0]        byte_data;
  logic              byte_ok, byte_ferr, rx_idle;
  logic [31:0]       staging;
  logic [IDLE_W-1:0] idle_cnt;
  logic              partial, timeout;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .byte_data(byte_data),
    .byte_ok  (byte_ok),
    .byte_ferr(byte_ferr),
    .idle     (rx_idle)
  );

  assign partial = (byte_idx != 2'd0);
  assign timeout = rx_idle && partial && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                idle_cnt <= '0;
    else if (!rx_idle || !partial || timeout) idle_cnt <= '0;
    else                                    idle_cnt <= idle_cnt + 1'b1;
  end

  // byte_ok only fires in STOP and timeout only in IDLE, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging    <= '0;
      dout       <= '0;
      word_valid <= 1'b0;
      word_cnt   <= '0;
      frame_err  <= 1'b0;
      byte_idx   <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_ferr) begin
        frame_err <= 1'b1;
        byte_idx  <= '0;
      end else if (byte_ok) begin
        if (byte_idx == LAST_LANE) begin
          dout       <= {byte_data, staging[23:0]};
          word_valid <= 1'b1;
          word_cnt   <= word_cnt + 8'd1;
          frame_err  <= 1'b0;
          byte_idx   <= '0;
        end else begin
          staging[{byte_idx, 3'b000} +: 8] <= byte_data;
          byte_idx <= byte_idx + 2'd1;
        end
      end else if (timeout) begin
        byte_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_in_dev.sv
// Bench: one DUT at 16 clocks/bit for directed scenarios, one at 4 clocks/bit for the 256-word wrap.
// Expected words come from a byte-list model of the 8N1 framing and word rules.
module tb_uart_in_dev;

  localparam int TO_BITS = 20;

  logic clk = 1'b0;
  logic rst;
  logic rxd16, rxd4;
  logic [31:0] dout16, dout4;
  logic        wv16, wv4;
  logic [7:0]  wc16, wc4;
  logic        fe16, fe4;
  logic [1:0]  bi16, bi4;

  always #5 clk = ~clk;

  uart_in_dev #(.CLKS_PER_BIT(16), .TIMEOUT_BITS(TO_BITS)) dut16 (
    .clk(clk), .rst(rst), .rxd(rxd16), .dout(dout16), .word_valid(wv16),
    .word_cnt(wc16), .frame_err(fe16), .byte_idx(bi16));

  uart_in_dev #(.CLKS_PER_BIT(4), .TIMEOUT_BITS(TO_BITS)) dut4 (
    .clk(clk), .rst(rst), .rxd(rxd4), .dout(dout4), .word_valid(wv4),
    .word_cnt(wc4), .frame_err(fe4), .byte_idx(bi4));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model, per instance: bytes held so far, last word, counts, error flag.
  logic [7:0]  part   [2][4];
  int          m_n    [2];
  logic [31:0] m_last [2];
  logic [7:0]  m_cnt  [2];
  logic        m_ferr [2];
  logic [31:0] exp16[$];
  logic [31:0] exp4[$];
  logic        wv16_prev = 1'b0;
  logic        wv4_prev  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int cpb(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0; m_last[i] = '0; m_cnt[i] = '0; m_ferr[i] = 1'b0;
    end
    exp16.delete();
    exp4.delete();
  endtask

  task automatic model_byte(input int i, input logic [7:0] b, input logic good);
    logic [31:0] w;
    if (!good) begin
      m_ferr[i] = 1'b1;
      m_n[i]    = 0;
    end else begin
      part[i][m_n[i]] = b;
      m_n[i]++;
      if (m_n[i] == 4) begin
        w = {part[i][3], part[i][2], part[i][1], part[i][0]};
        m_last[i] = w;
        m_cnt[i]  = m_cnt[i] + 8'd1;
        m_ferr[i] = 1'b0;
        m_n[i]    = 0;
        if (i == 0) exp16.push_back(w);
        else        exp4.push_back(w);
      end
    end
  endtask

  task automatic check_state(input int i);
    if (i == 0) begin
      check("dout16",      dout16,      m_last[0]);
      check("word_cnt16",  32'(wc16),   32'(m_cnt[0]));
      check("frame_err16", 32'(fe16),   32'(m_ferr[0]));
      check("byte_idx16",  32'(bi16),   32'(m_n[0]));
    end else begin
      check("dout4",       dout4,       m_last[1]);
      check("word_cnt4",   32'(wc4),    32'(m_cnt[1]));
      check("frame_err4",  32'(fe4),    32'(m_ferr[1]));
      check("byte_idx4",   32'(bi4),    32'(m_n[1]));
    end
  endtask

  task automatic drive(input int i, input logic v);
    if (i == 0) rxd16 = v;
    else        rxd4  = v;
  endtask

  // Model is updated before the frame because the DUT reports mid-stop-bit.
  task automatic send_frame(input int i, input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    model_byte(i, b, stop_bit);
    bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      drive(i, bits[k]);
      repeat (cpb(i)) @(negedge clk);
    end
    drive(i, 1'b1);
    repeat (3) @(negedge clk);
    check_state(i);
  endtask

  task automatic send_word(input int i, input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_frame(i, w[8*k +: 8], 1'b1);
  endtask

  // A line idle for more than TO_BITS bit periods discards any partial word.
  task automatic idle_bits(input int i, input int n);
    repeat (n * cpb(i)) @(negedge clk);
    if (n > TO_BITS) m_n[i] = 0;
    check_state(i);
  endtask

  always @(negedge clk) begin
    if (wv16) begin
      check("wv16_width", 32'(wv16_prev), 32'd0);
      check("wv16_expected", 32'(exp16.size() > 0), 32'd1);
      if (exp16.size() > 0) begin
        check("wv16_dout", dout16, exp16[0]);
        void'(exp16.pop_front());
      end
    end
    wv16_prev = wv16;
  end

  always @(negedge clk) begin
    if (wv4) begin
      check("wv4_width", 32'(wv4_prev), 32'd0);
      check("wv4_expected", 32'(exp4.size() > 0), 32'd1);
      if (exp4.size() > 0) begin
        check("wv4_dout", dout4, exp4[0]);
        void'(exp4.pop_front());
      end
    end
    wv4_prev = wv4;
  end

  initial begin
    rst = 1'b1; rxd16 = 1'b1; rxd4 = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_state(0);
    check("word_valid16_rst", 32'(wv16), 32'd0);
    check_state(1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic word, bytes LSB lane first.
    send_word(0, 32'h1234_5678);
    check("first_word", dout16, 32'h1234_5678);

    // Short low glitch is rejected at the start-bit sample.
    rxd16 = 1'b0;
    repeat (4) @(negedge clk);
    rxd16 = 1'b1;
    repeat (32) @(negedge clk);
    check_state(0);
    send_word(0, 32'hDEAD_BEEF);

    // Framing error drops the partial word; next good word clears the flag.
    send_frame(0, 8'h11, 1'b1);
    send_frame(0, 8'h22, 1'b0);
    idle_bits(0, 2);
    send_word(0, $urandom);

    // Timeout discards two stale bytes.
    send_frame(0, 8'($urandom), 1'b1);
    send_frame(0, 8'($urandom), 1'b1);
    idle_bits(0, 21);
    send_word(0, 32'h0403_0201);
    check("after_timeout", dout16, 32'h0403_0201);

    // Asynchronous reset in the middle of the second byte's data bits.
    send_frame(0, 8'hA1, 1'b1);
    rxd16 = 1'b0;
    repeat (16 + 40) @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_state(0);
    rxd16 = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_word(0, $urandom);

    // 256 random words on the fast instance: word_cnt wraps back to 0.
    for (int w = 0; w < 256; w++) begin
      send_word(1, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("wrap_cnt", 32'(wc4), 32'd0);

    repeat (8) @(negedge clk);
    check("pending16", 32'(exp16.size()), 32'd0);
    check("pending4",  32'(exp4.size()),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
